// File: rtl/rv_core_pkg.sv
// rv_core_pkg: shared fetch-stage types, reset PC and instruction field positions
package rv_core_pkg;
  typedef enum logic [1:0] {FETCH, WAIT, EXEC, HALT} fetch_state_e;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [6:0] OP_HLT = 7'b000_0000;
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_BIT = 30;
endpackage

// File: rtl/pc_next_logic.sv
// pc_next_logic: sequential/branch next-PC select with alignment check
module pc_next_logic #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            pc_src,
  input  logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] pc_next,
  output logic            misaligned
);
  always_comb begin
    pc_next = pc_src ? pc + imm_ext : pc + XLEN'(4);
    misaligned = |pc_next[1:0];
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing one instruction-memory request at a time and holding the instruction until commit
module fetch_unit
  import rv_core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            commit,
  input  logic            PCSrc,
  input  logic            load,
  input  logic [XLEN-1:0] ImmExt,
  output logic            halted
);
  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_plus4_q, pc_plus4_d, instr_q, instr_d, pc_next;
  logic req_q, valid_q, halted_q, misaligned, advance;
  pc_next_logic #(.XLEN(XLEN)) u_pc_next (
    .pc(pc_q),
    .pc_src(PCSrc),
    .imm_ext(ImmExt),
    .pc_next(pc_next),
    .misaligned(misaligned)
  );
  always_comb begin
    advance = load && !misaligned;
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    if (state_q == FETCH && imem_ready) begin
      state_d = imem_rvalid ? EXEC : WAIT;
      instr_d = imem_rvalid ? imem_rdata : instr_q;
    end
    if (state_q == WAIT && imem_rvalid) begin
      state_d = EXEC;
      instr_d = imem_rdata;
    end
    if (state_q == EXEC && commit) begin
      state_d = advance ? FETCH : HALT;
      pc_d = advance ? pc_next : pc_q;
    end
    pc_plus4_d = pc_d + XLEN'(4);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      pc_plus4_q <= RESET_PC + XLEN'(4);
      instr_q <= '0;
      req_q <= 1'b1;
      valid_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q <= instr_d;
      req_q <= state_d == FETCH;
      valid_q <= state_d == EXEC;
      halted_q <= state_d == HALT;
    end
  end
  assign imem_req = req_q;
  assign imem_addr = pc_q;
  assign pc = pc_q;
  assign pc_plus4 = pc_plus4_q;
  assign instr = instr_q;
  assign instr_valid = valid_q;
  assign halted = halted_q;
endmodule
